fir_out_decimator: RTL

//  Downstream stage of the FIR filter core: consumes one signed 8-bit filtered sample per in_valid strobe.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_sync_fifo.sv | 48 ++++
 rtl/fir_out_decimator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR output decimator.
// Sample/accumulator widths, FSM state encoding and the accumulator-to-sample saturator.
package fir_pkg;

  localparam int SAMPLE_W = 8;
  localparam int MAX_LOG2 = 3;
  localparam int ACC_W    = SAMPLE_W + MAX_LOG2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic {IDLE, ACCUM} decim_state_e;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  function automatic sample_t sat_to_sample(input acc_t a);
    sample_t r;
    if (a > acc_t'(SAMPLE_MAX))      r = SAMPLE_MAX;
    else if (a < acc_t'(SAMPLE_MIN)) r = SAMPLE_MIN;
    else                             r = a[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata_o shows the head entry whenever not empty.
// A push while full is accepted only if a pop happens in the same cycle.
module fir_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             wr_en, rd_en;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);
  assign wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
  assign rd_d  = rd_en ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fir_out_decimator.sv
// Decimates FIR samples by 2**decim_log2 (keep-first or average) into an FWFT output FIFO.
// DECIM_ROUND_EN adds round-half-up before the averaging shift; default build truncates.
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  input  logic [1:0]          decim_log2,
  input  logic                avg_mode,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ovf,
  input  logic                ovf_clr
);

  decim_state_e        state_q, state_d;
  logic [MAX_LOG2-1:0] phase_q, phase_d;
  acc_t                acc_q, acc_d;
  sample_t             first_q, first_d;
  logic [1:0]          log2_q, log2_d;
  logic                avg_q, avg_d;
  logic                ovf_q, ovf_d;
  sample_t             last_q, last_d;

  logic [1:0]          log2_in;
  logic [MAX_LOG2-1:0] last_ph;
  acc_t                samp_ext, fin_acc, rnd, shifted;
  sample_t             fin_first, result;
  logic [1:0]          fin_log2;
  logic                fin_avg, done;
  logic                fifo_full, fifo_empty, pop;
  logic [SAMPLE_W-1:0] fifo_rdata;

  assign log2_in  = (decim_log2 > 2'(MAX_LOG2)) ? 2'(MAX_LOG2) : decim_log2;
  assign last_ph  = ~({MAX_LOG2{1'b1}} << log2_q);
  assign samp_ext = acc_t'(sample_t'(in_data));

  // fin_* describe the frame as it stands after this cycle's sample, whether it completes now or not.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    first_d   = first_q;
    log2_d    = log2_q;
    avg_d     = avg_q;
    done      = 1'b0;
    fin_acc   = acc_q + samp_ext;
    fin_first = first_q;
    fin_log2  = log2_q;
    fin_avg   = avg_q;
    if (in_valid) begin
      if (state_q == IDLE) begin
        log2_d    = log2_in;
        avg_d     = avg_mode;
        acc_d     = samp_ext;
        first_d   = sample_t'(in_data);
        fin_acc   = samp_ext;
        fin_first = sample_t'(in_data);
        fin_log2  = log2_in;
        fin_avg   = avg_mode;
        if (log2_in == 2'd0) begin
          done    = 1'b1;
          phase_d = '0;
        end else begin
          phase_d = MAX_LOG2'(1);
          state_d = ACCUM;
        end
      end else begin
        acc_d   = fin_acc;
        phase_d = phase_q + 1'b1;
        if (phase_q == last_ph) begin
          done    = 1'b1;
          phase_d = '0;
          state_d = IDLE;
        end
      end
    end
  end

  always_comb begin
`ifdef DECIM_ROUND_EN
    rnd     = (fin_log2 == 2'd0) ? '0 : (acc_t'(1) << (fin_log2 - 2'd1));
`else
    rnd     = '0;
`endif
    shifted = (fin_acc + rnd) >>> fin_log2;
    result  = fin_avg ? sat_to_sample(shifted) : fin_first;
  end

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign ovf_d     = (done & fifo_full & ~pop) | (ovf_q & ~ovf_clr);
  assign last_d    = pop ? sample_t'(fifo_rdata) : last_q;
  assign out_data  = fifo_empty ? last_q : fifo_rdata;
  assign ovf       = ovf_q;

  fir_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (done),
    .wdata_i (result),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      acc_q   <= '0;
      first_q <= '0;
      log2_q  <= '0;
      avg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      first_q <= first_d;
      log2_q  <= log2_d;
      avg_q   <= avg_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

endmodule
